// File: rtl/om_stream_pkg.sv
// Shared types and helpers for the om_stream merge/split family.
// Holds the merge FSM state type, the round-robin pick helper and the
// per-channel statistics counter width.
package om_stream_pkg;

  localparam int STATS_W = 32;
  // Widest channel count rr_pick can scan (matches the NUM_CH upper bound).
  localparam int RR_MAX  = 16;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_t;

  typedef struct packed {
    logic       found;
    logic [3:0] idx;
  } pick_t;

  // Return the first asserted bit of valid[0..n-1], scanning upward from ptr
  // and wrapping at n. The wrap is an explicit compare so that n need not be
  // a power of two. Offsets are walked from largest to smallest so the
  // smallest offset from ptr is the one that sticks.
  function automatic pick_t rr_pick(input logic [RR_MAX-1:0] valid,
                                    input logic [3:0]        ptr,
                                    input logic [4:0]        n);
    pick_t      res;
    logic [4:0] pos;
    res.found = 1'b0;
    res.idx   = 4'd0;
    pos       = 5'd0;
    for (int i = RR_MAX - 1; i >= 0; i--) begin
      pos = {1'b0, ptr} + 5'(i);
      if (pos >= n) begin
        pos = pos - n;
      end else begin
        pos = pos;
      end
      if ((5'(i) < n) && valid[pos[3:0]]) begin
        res.found = 1'b1;
        res.idx   = pos[3:0];
      end else begin
        res = res;
      end
    end
    return res;
  endfunction

endpackage

// File: rtl/om_rr_arbiter.sv
// Round-robin arbiter: combinational pick starting at rr_ptr plus the rr_ptr
// register itself. The pointer moves to the channel after adv_from whenever
// advance is pulsed, so the channel just served is tried last next time.
module om_rr_arbiter
  import om_stream_pkg::*;
#(
  parameter  int NUM_CH = 4,
  localparam int CH_W   = $clog2(NUM_CH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NUM_CH-1:0] req,
  input  logic              advance,
  input  logic [CH_W-1:0]   adv_from,
  output logic [CH_W-1:0]   pick,
  output logic              found
);

  logic [RR_MAX-1:0] req_ext;
  logic [CH_W-1:0]   rr_ptr;
  pick_t             res;

  // Widen the request vector to the fixed width the pick helper scans.
  always_comb begin
    req_ext             = {RR_MAX{1'b0}};
    req_ext[NUM_CH-1:0] = req;
  end

  // Scan requests in round-robin order starting at rr_ptr.
  always_comb begin
    res   = rr_pick(req_ext, 4'(rr_ptr), 5'(NUM_CH));
    pick  = CH_W'(res.idx);
    found = res.found;
  end

  // Pointer register: after serving a channel, start the next scan just past it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rr_ptr <= {CH_W{1'b0}};
    end else if (advance) begin
      if (adv_from == CH_W'(NUM_CH - 1)) begin
        rr_ptr <= {CH_W{1'b0}};
      end else begin
        rr_ptr <= adv_from + CH_W'(1);
      end
    end else begin
      rr_ptr <= rr_ptr;
    end
  end

endmodule

// File: rtl/om_stream_merge.sv
// N-to-1 AXI-Stream merger with packet-granular round-robin arbitration.
// A channel is granted in IDLE (one bubble cycle per packet) and keeps the
// grant until its last beat is accepted; packets longer than MAX_BEATS are
// cut with tlast forced and the sticky trunc_err raised.
// Optional build macro OM_STREAM_MERGE_STATS_EN adds per-channel packet
// counters (pkt_count) with a synchronous clear (stats_clr).
module om_stream_merge
  import om_stream_pkg::*;
#(
  parameter  int NUM_CH    = 4,
  parameter  int DATA_W    = 64,
  parameter  int TID_W     = 4,
  parameter  int MAX_BEATS = 32,
  localparam int CH_W      = $clog2(NUM_CH)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NUM_CH-1:0]        in_tvalid,
  output logic [NUM_CH-1:0]        in_tready,
  input  logic [NUM_CH*DATA_W-1:0] in_tdata,
  input  logic [NUM_CH*TID_W-1:0]  in_tid,
  input  logic [NUM_CH-1:0]        in_tlast,
  output logic                     out_tvalid,
  input  logic                     out_tready,
  output logic [DATA_W-1:0]        out_tdata,
  output logic [TID_W-1:0]         out_tid,
  output logic [CH_W-1:0]          out_tch,
  output logic                     out_tlast,
  output logic                     trunc_err
`ifdef OM_STREAM_MERGE_STATS_EN
  ,
  input  logic                      stats_clr,
  output logic [NUM_CH*STATS_W-1:0] pkt_count
`endif
);

  localparam int BC_W = $clog2(MAX_BEATS + 1);

  state_t            state;
  state_t            state_nxt;
  logic [CH_W-1:0]   grant;
  logic [BC_W-1:0]   beat_cnt;
  logic [CH_W-1:0]   pick;
  logic              found;
  logic              sel_valid;
  logic              sel_last;
  logic [DATA_W-1:0] sel_data;
  logic [TID_W-1:0]  sel_tid;
  logic              ready_sel;
  logic              hs;
  logic              last;
  logic              eop;

  om_rr_arbiter #(
    .NUM_CH (NUM_CH)
  ) u_arb (
    .clk      (clk),
    .rst      (rst),
    .req      (in_tvalid),
    .advance  (eop),
    .adv_from (grant),
    .pick     (pick),
    .found    (found)
  );

  // Mux the granted channel's beat onto the internal select bus.
  always_comb begin
    sel_valid = 1'b0;
    sel_last  = 1'b0;
    sel_data  = {DATA_W{1'b0}};
    sel_tid   = {TID_W{1'b0}};
    for (int i = 0; i < NUM_CH; i++) begin
      if (grant == CH_W'(i)) begin
        sel_valid = in_tvalid[i];
        sel_last  = in_tlast[i];
        sel_data  = in_tdata[i*DATA_W +: DATA_W];
        sel_tid   = in_tid[i*TID_W +: TID_W];
      end else begin
        sel_valid = sel_valid;
      end
    end
  end

  // Handshake, forced-last and ready: only the granted channel sees ready.
  always_comb begin
    ready_sel = (state == BUSY) && (!out_tvalid || out_tready);
    hs        = ready_sel && sel_valid;
    last      = sel_last || (beat_cnt == BC_W'(MAX_BEATS - 1));
    eop       = hs && last;
    in_tready = {NUM_CH{1'b0}};
    if (ready_sel) begin
      in_tready[grant] = 1'b1;
    end else begin
      in_tready = {NUM_CH{1'b0}};
    end
  end

  // Next-state logic: grant in IDLE, release on the last accepted beat.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (found) begin
          state_nxt = BUSY;
        end else begin
          state_nxt = IDLE;
        end
      end
      BUSY: begin
        if (eop) begin
          state_nxt = IDLE;
        end else begin
          state_nxt = BUSY;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Capture the arbiter's pick as the grant when leaving IDLE.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      grant <= {CH_W{1'b0}};
    end else if ((state == IDLE) && found) begin
      grant <= pick;
    end else begin
      grant <= grant;
    end
  end

  // Beats accepted in the current packet; restarts at every packet end.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      beat_cnt <= {BC_W{1'b0}};
    end else if (hs) begin
      if (last) begin
        beat_cnt <= {BC_W{1'b0}};
      end else begin
        beat_cnt <= beat_cnt + BC_W'(1);
      end
    end else begin
      beat_cnt <= beat_cnt;
    end
  end

  // Output register: load on handshake, drain when the consumer takes it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_tvalid <= 1'b0;
      out_tdata  <= {DATA_W{1'b0}};
      out_tid    <= {TID_W{1'b0}};
      out_tch    <= {CH_W{1'b0}};
      out_tlast  <= 1'b0;
    end else if (hs) begin
      out_tvalid <= 1'b1;
      out_tdata  <= sel_data;
      out_tid    <= sel_tid;
      out_tch    <= grant;
      out_tlast  <= last;
    end else if (out_tready) begin
      out_tvalid <= 1'b0;
    end else begin
      out_tvalid <= out_tvalid;
    end
  end

  // Sticky truncation flag: packet ended by the length guard, not by tlast.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      trunc_err <= 1'b0;
    end else if (eop && !sel_last) begin
      trunc_err <= 1'b1;
    end else begin
      trunc_err <= trunc_err;
    end
  end

`ifdef OM_STREAM_MERGE_STATS_EN
  // Per-channel packet counters; a clear overrides a same-cycle increment.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pkt_count <= {(NUM_CH*STATS_W){1'b0}};
    end else if (stats_clr) begin
      pkt_count <= {(NUM_CH*STATS_W){1'b0}};
    end else if (eop) begin
      for (int i = 0; i < NUM_CH; i++) begin
        if (grant == CH_W'(i)) begin
          pkt_count[i*STATS_W +: STATS_W] <= pkt_count[i*STATS_W +: STATS_W] + 32'd1;
        end
      end
    end else begin
      pkt_count <= pkt_count;
    end
  end
`endif

endmodule
